// File: rtl/ex_muldiv_pkg.sv
// Shared encodings for the execute stage: bus widths, op/sel codes, FSM states.
package ex_muldiv_pkg;

    localparam int ALUOP_W   = 8;
    localparam int ALUSEL_W  = 3;
    localparam int REGADDR_W = 5;

    typedef logic [ALUOP_W-1:0]   aluop_bus_t;
    typedef logic [ALUSEL_W-1:0]  alusel_bus_t;
    typedef logic [REGADDR_W-1:0] regaddr_bus_t;

    localparam logic RST_ENABLE = 1'b0;
    localparam logic STOP       = 1'b1;
    localparam logic NO_STOP    = 1'b0;

    // result classes
    localparam alusel_bus_t SEL_NOP   = 3'b000;
    localparam alusel_bus_t SEL_LOGIC = 3'b001;
    localparam alusel_bus_t SEL_SHIFT = 3'b010;
    localparam alusel_bus_t SEL_MOVE  = 3'b011;
    localparam alusel_bus_t SEL_ARITH = 3'b100;
    localparam alusel_bus_t SEL_MUL   = 3'b101;
    localparam alusel_bus_t SEL_JUMP  = 3'b110;

    // operation codes
    localparam aluop_bus_t OP_NOP   = 8'b0000_0000;
    localparam aluop_bus_t OP_AND   = 8'b0010_0100;
    localparam aluop_bus_t OP_OR    = 8'b0010_0101;
    localparam aluop_bus_t OP_XOR   = 8'b0010_0110;
    localparam aluop_bus_t OP_NOR   = 8'b0010_0111;
    localparam aluop_bus_t OP_SLL   = 8'b0111_1100;
    localparam aluop_bus_t OP_SRL   = 8'b0000_0010;
    localparam aluop_bus_t OP_SRA   = 8'b0000_0011;
    localparam aluop_bus_t OP_SLT   = 8'b0010_1010;
    localparam aluop_bus_t OP_SLTU  = 8'b0010_1011;
    localparam aluop_bus_t OP_ADD   = 8'b0010_0000;
    localparam aluop_bus_t OP_ADDU  = 8'b0010_0001;
    localparam aluop_bus_t OP_SUB   = 8'b0010_0010;
    localparam aluop_bus_t OP_SUBU  = 8'b0010_0011;
    localparam aluop_bus_t OP_ADDIU = 8'b0101_0110;
    localparam aluop_bus_t OP_JAL   = 8'b0101_0000;
    localparam aluop_bus_t OP_MULT  = 8'b0001_1000;
    localparam aluop_bus_t OP_MULTU = 8'b0001_1001;
    localparam aluop_bus_t OP_MUL   = 8'b1010_1001;
    localparam aluop_bus_t OP_DIV   = 8'b0001_1010;
    localparam aluop_bus_t OP_DIVU  = 8'b0001_1011;
    localparam aluop_bus_t OP_MFHI  = 8'b0001_0000;
    localparam aluop_bus_t OP_MTHI  = 8'b0001_0001;
    localparam aluop_bus_t OP_MFLO  = 8'b0001_0010;
    localparam aluop_bus_t OP_MTLO  = 8'b0001_0011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic is_mul_op(aluop_bus_t op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MUL);
    endfunction

    function automatic logic is_div_op(aluop_bus_t op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_muldiv_divider.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// signs restored on the outputs. A zero divisor loads the fixed result at start.
module ex_divider #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              signed_op,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              done,
    output logic [DATA_W-1:0] quotient,
    output logic [DATA_W-1:0] remainder
);
    import ex_muldiv_pkg::*;

    localparam int CNT_W = $clog2(DATA_W);

    logic              busy;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] rem_q;
    logic [DATA_W-1:0] quo_q;
    logic [DATA_W-1:0] dvs_q;
    logic              q_neg;
    logic              r_neg;
    logic              dvd_neg;
    logic              dvs_neg;
    logic [DATA_W:0]   shifted;
    logic [DATA_W:0]   diff;

    assign dvd_neg = signed_op & dividend[DATA_W-1];
    assign dvs_neg = signed_op & divisor[DATA_W-1];

    // trial subtraction of the divisor from the partial remainder
    always_comb begin
        shifted = {rem_q, quo_q[DATA_W-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    // operand load, iteration and abort
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            busy  <= 1'b0;
            cnt   <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            q_neg <= 1'b0;
            r_neg <= 1'b0;
        end else if (abort) begin
            busy <= 1'b0;
        end else if (start) begin
            if (divisor == '0) begin
                quo_q <= '1;
                rem_q <= dividend;
                q_neg <= 1'b0;
                r_neg <= 1'b0;
                busy  <= 1'b0;
            end else begin
                quo_q <= dvd_neg ? -dividend : dividend;
                dvs_q <= dvs_neg ? -divisor : divisor;
                rem_q <= '0;
                q_neg <= dvd_neg ^ dvs_neg;
                r_neg <= dvd_neg;
                cnt   <= CNT_W'(DATA_W - 1);
                busy  <= 1'b1;
            end
        end else if (busy) begin
            if (diff[DATA_W]) begin
                rem_q <= shifted[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b0};
            end else begin
                rem_q <= diff[DATA_W-1:0];
                quo_q <= {quo_q[DATA_W-2:0], 1'b1};
            end
            if (cnt == '0) busy <= 1'b0;
            else           cnt  <= cnt - 1'b1;
        end
    end

    assign done      = busy & (cnt == '0);
    assign quotient  = q_neg ? -quo_q : quo_q;
    assign remainder = r_neg ? -rem_q : rem_q;

endmodule

// File: rtl/ex_muldiv.sv
// Execute stage: single-cycle ALU paths plus pipelined multiply, iterative
// divide and architectural HI/LO, holding the pipeline while busy.
//
// state   | meaning
// IDLE    | single-cycle ops; launches mul/div
// MUL     | product travelling down the multiplier register chain
// DIV     | divider iterating, one quotient bit per cycle
// DONE    | result presented; HI/LO commit on the edge leaving this state
module ex_muldiv
    import ex_muldiv_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int MUL_STAGES = 2,
    parameter int SHAMT_W    = $clog2(DATA_W)
) (
    input  logic               clk,
    input  logic               rst,
    input  aluop_bus_t         aluop_i,
    input  alusel_bus_t        alusel_i,
    input  logic [DATA_W-1:0]  reg1_i,
    input  logic [DATA_W-1:0]  reg2_i,
    input  regaddr_bus_t       wd_i,
    input  logic               wreg_i,
    input  logic [DATA_W-1:0]  link_address_i,
    input  logic               stall_i,
    input  logic               flush_i,
    output regaddr_bus_t       wd_o,
    output logic               wreg_o,
    output logic [DATA_W-1:0]  wdata_o,
    output logic [DATA_W-1:0]  hi_o,
    output logic [DATA_W-1:0]  lo_o,
    output logic               stallreq
);
    localparam int MCNT_W = (MUL_STAGES > 1) ? $clog2(MUL_STAGES) : 1;

    state_t                            state;
    logic [DATA_W-1:0]                 hi_q;
    logic [DATA_W-1:0]                 lo_q;
    logic [DATA_W-1:0]                 mag_a;
    logic [DATA_W-1:0]                 mag_b;
    logic                              prod_neg;
    logic [MUL_STAGES-1:0][2*DATA_W-1:0] prod_pipe;
    logic [MCNT_W-1:0]                 mul_cnt;
    logic                              op_low;
    logic                              op_div;
    logic [2*DATA_W-1:0]               mul_result;
    logic [2*DATA_W-1:0]               done_result;
    logic                              mul_req;
    logic                              div_req;
    logic                              div_start;
    logic                              div_done;
    logic [DATA_W-1:0]                 div_quo;
    logic [DATA_W-1:0]                 div_rem;
    logic [SHAMT_W-1:0]                shamt;
    logic                              signed_mul;
    logic [DATA_W-1:0]                 result;

    assign mul_req    = is_mul_op(aluop_i);
    assign div_req    = is_div_op(aluop_i);
    assign div_start  = (state == ST_IDLE) & div_req & ~flush_i;
    assign signed_mul = (aluop_i != OP_MULTU);
    assign shamt      = reg1_i[SHAMT_W-1:0];

    ex_divider #(.DATA_W(DATA_W)) u_divider (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start),
        .abort     (flush_i),
        .signed_op (aluop_i == OP_DIV),
        .dividend  (reg1_i),
        .divisor   (reg2_i),
        .done      (div_done),
        .quotient  (div_quo),
        .remainder (div_rem)
    );

    assign mul_result  = prod_neg ? -prod_pipe[MUL_STAGES-1] : prod_pipe[MUL_STAGES-1];
    assign done_result = op_div ? {div_rem, div_quo} : mul_result;

    // sequencing FSM, multiplier chain and HI/LO registers
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE) begin
            state     <= ST_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            mag_a     <= '0;
            mag_b     <= '0;
            prod_neg  <= 1'b0;
            prod_pipe <= '0;
            mul_cnt   <= '0;
            op_low    <= 1'b0;
            op_div    <= 1'b0;
        end else if (flush_i) begin
            state <= ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (mul_req) begin
                        mag_a    <= (signed_mul & reg1_i[DATA_W-1]) ? -reg1_i : reg1_i;
                        mag_b    <= (signed_mul & reg2_i[DATA_W-1]) ? -reg2_i : reg2_i;
                        prod_neg <= signed_mul & (reg1_i[DATA_W-1] ^ reg2_i[DATA_W-1]);
                        mul_cnt  <= MCNT_W'(MUL_STAGES - 1);
                        op_low   <= (aluop_i == OP_MUL);
                        op_div   <= 1'b0;
                        state    <= ST_MUL;
                    end else if (div_req) begin
                        op_low <= 1'b0;
                        op_div <= 1'b1;
                        state  <= (reg2_i == '0) ? ST_DONE : ST_DIV;
                    end else if (!stall_i) begin
                        if (aluop_i == OP_MTHI) hi_q <= reg1_i;
                        if (aluop_i == OP_MTLO) lo_q <= reg1_i;
                    end
                end
                ST_MUL: begin
                    prod_pipe[0] <= {{DATA_W{1'b0}}, mag_a} * {{DATA_W{1'b0}}, mag_b};
                    for (int i = 1; i < MUL_STAGES; i++) prod_pipe[i] <= prod_pipe[i-1];
                    if (mul_cnt == '0) state   <= ST_DONE;
                    else               mul_cnt <= mul_cnt - 1'b1;
                end
                ST_DIV: begin
                    if (div_done) state <= ST_DONE;
                end
                ST_DONE: begin
                    // a held stage keeps DONE so the commit happens exactly once
                    if (!stall_i) begin
                        state <= ST_IDLE;
                        if (!op_low) {hi_q, lo_q} <= done_result;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // single-cycle result select
    always_comb begin
        result = '0;
        case (alusel_i)
            SEL_LOGIC: begin
                case (aluop_i)
                    OP_OR:   result = reg1_i | reg2_i;
                    OP_AND:  result = reg1_i & reg2_i;
                    OP_XOR:  result = reg1_i ^ reg2_i;
                    OP_NOR:  result = ~(reg1_i | reg2_i);
                    default: result = '0;
                endcase
            end
            SEL_SHIFT: begin
                case (aluop_i)
                    OP_SLL:  result = reg2_i << shamt;
                    OP_SRL:  result = reg2_i >> shamt;
                    OP_SRA:  result = DATA_W'($signed(reg2_i) >>> shamt);
                    default: result = '0;
                endcase
            end
            SEL_MOVE: begin
                case (aluop_i)
                    OP_MFHI: result = hi_q;
                    OP_MFLO: result = lo_q;
                    default: result = '0;
                endcase
            end
            SEL_ARITH: begin
                case (aluop_i)
                    OP_ADD, OP_ADDU, OP_ADDIU: result = reg1_i + reg2_i;
                    OP_SUB, OP_SUBU:           result = reg1_i - reg2_i;
                    OP_SLT:  result = {{(DATA_W-1){1'b0}}, ($signed(reg1_i) < $signed(reg2_i))};
                    OP_SLTU: result = {{(DATA_W-1){1'b0}}, (reg1_i < reg2_i)};
                    default: result = '0;
                endcase
            end
            SEL_MUL: begin
                if ((state == ST_DONE) && op_low) result = mul_result[DATA_W-1:0];
            end
            SEL_JUMP: result = link_address_i;
            default:  result = '0;
        endcase
    end

    // reset and flush silence the pipeline-facing outputs immediately
    assign stallreq = (rst != RST_ENABLE) && !flush_i &&
                      (((state == ST_IDLE) && (mul_req || div_req)) ||
                       (state == ST_MUL) || (state == ST_DIV)) ? STOP : NO_STOP;
    assign wreg_o   = (rst != RST_ENABLE) & wreg_i & ~stallreq & ~flush_i &
                      ~((state == ST_DONE) & ~op_low);
    assign wdata_o  = (rst != RST_ENABLE) ? result : '0;
    assign wd_o     = wd_i;
    assign hi_o     = hi_q;
    assign lo_o     = lo_q;

endmodule

// File: tb/tb_ex_muldiv.sv
// Self-checking bench for ex_muldiv: acts as the pipeline around the stage,
// holding each instruction while stallreq is high.
module tb_ex_muldiv;
    import ex_muldiv_pkg::*;

    localparam int MUL_STAGES = 2;
    localparam int MUL_STALLS = MUL_STAGES + 1;
    localparam int DIV_STALLS = 33;

    logic         clk = 1'b0;
    logic         rst;
    aluop_bus_t   aluop_i;
    alusel_bus_t  alusel_i;
    logic [31:0]  reg1_i, reg2_i, link_address_i;
    regaddr_bus_t wd_i, wd_o;
    logic         wreg_i, stall_i, flush_i;
    logic         wreg_o, stallreq;
    logic [31:0]  wdata_o, hi_o, lo_o;

    int compared   = 0;
    int mismatched = 0;
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    ex_muldiv #(.DATA_W(32), .MUL_STAGES(MUL_STAGES)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .link_address_i(link_address_i), .stall_i(stall_i), .flush_i(flush_i),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .hi_o(hi_o), .lo_o(lo_o),
        .stallreq(stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] ref_single(aluop_bus_t op, logic [31:0] a, logic [31:0] b,
                                               logic [31:0] link);
        int n;
        n = int'(a[4:0]);
        case (op)
            OP_OR:   return a | b;
            OP_AND:  return a & b;
            OP_XOR:  return a ^ b;
            OP_NOR:  return ~(a | b);
            OP_SLL:  return b << n;
            OP_SRL:  return b >> n;
            OP_SRA:  return (b >> n) | (b[31] ? ~(32'hFFFF_FFFF >> n) : 32'h0);
            OP_ADD, OP_ADDU, OP_ADDIU: return 32'(a + b);
            OP_SUB, OP_SUBU:           return 32'(a - b);
            OP_SLT:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            OP_JAL:  return link;
            default: return 32'h0;
        endcase
    endfunction

    task automatic drive_nop();
        aluop_i = OP_NOP; alusel_i = SEL_NOP; reg1_i = '0; reg2_i = '0; wreg_i = 1'b0;
    endtask

    // issue one instruction and hold it until stallreq drops; sample the
    // result in the non-stalled cycle, then advance past its ending edge
    task automatic run_op(input aluop_bus_t op, input alusel_bus_t sel, input logic [31:0] a,
                          input logic [31:0] b, input logic wr, output int stalls,
                          output logic [31:0] wd, output logic wo);
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wreg_i = wr;
        wd_i = 5'($urandom_range(0, 31));
        stalls = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stallreq) break;
            stalls++;
            @(posedge clk); #1;
        end
        wd = wdata_o; wo = wreg_o;
        @(posedge clk); #1;
        drive_nop();
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        int st; logic [31:0] wd; logic wo;
        run_op(OP_MTHI, SEL_NOP, h, 32'h0, 1'b0, st, wd, wo);
        run_op(OP_MTLO, SEL_NOP, l, 32'h0, 1'b0, st, wd, wo);
        model_hi = h; model_lo = l;
        compared++;
        if (hi_o !== model_hi || lo_o !== model_lo) begin
            mismatched++;
            $display("FAIL mthi_mtlo: got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, model_hi, model_lo);
        end
    endtask

    task automatic test_reset();
        aluop_i = OP_OR; alusel_i = SEL_LOGIC; reg1_i = 32'h1234; reg2_i = 32'h1;
        wreg_i = 1'b1; #2;
        compared++;
        if (stallreq !== 1'b0 || wreg_o !== 1'b0 || wdata_o !== 32'h0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            mismatched++;
            $display("FAIL reset_state: got stallreq=%b wreg=%b wdata=%h hi=%h lo=%h expected all zero",
                     stallreq, wreg_o, wdata_o, hi_o, lo_o);
        end
        drive_nop();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_cycle();
        int st; logic [31:0] wd, a, b, exp; logic wo;
        aluop_bus_t op; alusel_bus_t sel;
        for (int i = 0; i < 40; i++) begin
            a = $urandom; b = $urandom;
            case (i)
                0: begin op = OP_SRA;  sel = SEL_SHIFT; a = 32'd4; b = 32'h8000_0000; end
                1: begin op = OP_SLTU; sel = SEL_ARITH; a = 32'd1; b = 32'hFFFF_FFFF; end
                2: begin op = OP_SLT;  sel = SEL_ARITH; a = 32'd1; b = 32'hFFFF_FFFF; end
                3: begin op = OP_ADD;  sel = SEL_ARITH; a = 32'hFFFF_FFFF; b = 32'd2; end
                default: begin
                    case ($urandom_range(0, 13))
                        0:  begin op = OP_OR;    sel = SEL_LOGIC; end
                        1:  begin op = OP_AND;   sel = SEL_LOGIC; end
                        2:  begin op = OP_XOR;   sel = SEL_LOGIC; end
                        3:  begin op = OP_NOR;   sel = SEL_LOGIC; end
                        4:  begin op = OP_SLL;   sel = SEL_SHIFT; end
                        5:  begin op = OP_SRL;   sel = SEL_SHIFT; end
                        6:  begin op = OP_SRA;   sel = SEL_SHIFT; end
                        7:  begin op = OP_ADDU;  sel = SEL_ARITH; end
                        8:  begin op = OP_SUB;   sel = SEL_ARITH; end
                        9:  begin op = OP_SUBU;  sel = SEL_ARITH; end
                        10: begin op = OP_SLT;   sel = SEL_ARITH; end
                        11: begin op = OP_SLTU;  sel = SEL_ARITH; end
                        12: begin op = OP_ADDIU; sel = SEL_ARITH; end
                        default: begin op = OP_JAL; sel = SEL_JUMP; end
                    endcase
                end
            endcase
            link_address_i = $urandom;
            exp = ref_single(op, a, b, link_address_i);
            run_op(op, sel, a, b, 1'b1, st, wd, wo);
            compared++;
            if (wd !== exp || wo !== 1'b1 || st != 0) begin
                mismatched++;
                $display("FAIL single[%0d] op=%h: got data=%h wreg=%b stalls=%0d expected data=%h wreg=1 stalls=0",
                         i, op, wd, wo, st, exp);
            end
        end
    endtask

    task automatic test_mult();
        int st; logic [31:0] wd, a, b; logic wo; logic [63:0] p;
        aluop_bus_t op;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom;
            case (i)
                0: begin op = OP_MULT; a = 32'hFFFF_FFFD; b = 32'd7; end
                1: begin op = OP_MUL;  a = 32'h0001_0000; b = 32'h0001_0000; end
                2: begin op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF; end
                default: begin
                    case ($urandom_range(0, 2))
                        0: op = OP_MULT;
                        1: op = OP_MULTU;
                        default: op = OP_MUL;
                    endcase
                end
            endcase
            if (op == OP_MULTU) p = {32'h0, a} * {32'h0, b};
            else                p = 64'(longint'($signed(a)) * longint'($signed(b)));
            run_op(op, (op == OP_MUL) ? SEL_MUL : SEL_NOP, a, b, op == OP_MUL, st, wd, wo);
            compared++;
            if (st != MUL_STALLS) begin
                mismatched++;
                $display("FAIL mul_stalls[%0d]: got %0d expected %0d", i, st, MUL_STALLS);
            end
            if (op == OP_MUL) begin
                compared++;
                if (wd !== p[31:0] || wo !== 1'b1 || hi_o !== model_hi || lo_o !== model_lo) begin
                    mismatched++;
                    $display("FAIL mul_low[%0d]: got data=%h wreg=%b hi=%h lo=%h expected data=%h wreg=1 hi=%h lo=%h",
                             i, wd, wo, hi_o, lo_o, p[31:0], model_hi, model_lo);
                end
            end else begin
                model_hi = p[63:32]; model_lo = p[31:0];
                compared++;
                if (hi_o !== model_hi || lo_o !== model_lo || wo !== 1'b0) begin
                    mismatched++;
                    $display("FAIL mult_hilo[%0d]: got hi=%h lo=%h wreg=%b expected hi=%h lo=%h wreg=0",
                             i, hi_o, lo_o, wo, model_hi, model_lo);
                end
            end
            if (i == 0) begin
                run_op(OP_MFLO, SEL_MOVE, 32'h0, 32'h0, 1'b1, st, wd, wo);
                compared++;
                if (wd !== 32'hFFFF_FFEB) begin
                    mismatched++;
                    $display("FAIL mflo_after_mult: got %h expected ffffffeb", wd);
                end
                run_op(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1, st, wd, wo);
                compared++;
                if (wd !== 32'hFFFF_FFFF) begin
                    mismatched++;
                    $display("FAIL mfhi_after_mult: got %h expected ffffffff", wd);
                end
            end
        end
    endtask

    task automatic test_div();
        int st, exp_st; logic [31:0] wd, a, b, q, r; logic wo;
        aluop_bus_t op; longint sa, sb;
        for (int i = 0; i < 12; i++) begin
            a = $urandom; b = $urandom >> $urandom_range(0, 31);
            op = ($urandom_range(0, 1) == 0) ? OP_DIV : OP_DIVU;
            case (i)
                0: begin op = OP_DIV;  a = 32'hFFFF_FFF9; b = 32'd2; end
                1: begin op = OP_DIVU; a = 32'hFFFF_FFFF; b = 32'h10; end
                2: begin op = OP_DIV;  a = 32'd5; b = 32'd0; end
                3: begin op = OP_DIV;  a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                4: begin op = OP_DIVU; a = 32'h1234_5678; b = 32'd0; end
                5: begin op = OP_DIV;  a = 32'd100; b = 32'hFFFF_FFF9; end
                default: ;
            endcase
            if (b == 32'h0) begin
                q = 32'hFFFF_FFFF; r = a; exp_st = 1;
            end else if (op == OP_DIV) begin
                sa = longint'($signed(a)); sb = longint'($signed(b));
                q = 32'(sa / sb); r = 32'(sa % sb); exp_st = DIV_STALLS;
            end else begin
                q = a / b; r = a % b; exp_st = DIV_STALLS;
            end
            run_op(op, SEL_NOP, a, b, 1'b0, st, wd, wo);
            model_hi = r; model_lo = q;
            compared++;
            if (st != exp_st || hi_o !== model_hi || lo_o !== model_lo) begin
                mismatched++;
                $display("FAIL div[%0d] %h/%h: got stalls=%0d hi=%h lo=%h expected stalls=%0d hi=%h lo=%h",
                         i, a, b, st, hi_o, lo_o, exp_st, model_hi, model_lo);
            end
        end
    endtask

    task automatic test_flush();
        int st; logic [31:0] wd; logic wo;
        set_hilo(32'hA5A5_0001, 32'h5A5A_0002);
        aluop_i = OP_DIV; alusel_i = SEL_NOP; reg1_i = $urandom; reg2_i = 32'd3; wreg_i = 1'b1;
        repeat (10) @(posedge clk);
        #1 flush_i = 1'b1;
        #1;
        compared++;
        if (stallreq !== 1'b0 || wreg_o !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_same_cycle: got stallreq=%b wreg=%b expected 0 0", stallreq, wreg_o);
        end
        @(posedge clk); #1;
        flush_i = 1'b0;
        drive_nop();
        repeat (40) @(posedge clk);
        #1;
        compared++;
        if (hi_o !== model_hi || lo_o !== model_lo || stallreq !== 1'b0) begin
            mismatched++;
            $display("FAIL flush_no_commit: got hi=%h lo=%h stallreq=%b expected hi=%h lo=%h stallreq=0",
                     hi_o, lo_o, stallreq, model_hi, model_lo);
        end
        run_op(OP_MULTU, SEL_NOP, 32'd6, 32'd7, 1'b0, st, wd, wo);
        model_hi = 32'h0; model_lo = 32'd42;
        compared++;
        if (st != MUL_STALLS || hi_o !== model_hi || lo_o !== model_lo) begin
            mismatched++;
            $display("FAIL after_flush_idle: got stalls=%0d hi=%h lo=%h expected stalls=%0d hi=0 lo=2a",
                     st, hi_o, lo_o, MUL_STALLS);
        end
    endtask

    task automatic test_stall_in_done();
        int st; logic [31:0] wd, old_hi, old_lo; logic wo; bit ok;
        set_hilo(32'h1111_1111, 32'h2222_2222);
        old_hi = model_hi; old_lo = model_lo;
        aluop_i = OP_DIVU; alusel_i = SEL_NOP; reg1_i = 32'd1000; reg2_i = 32'd7; wreg_i = 1'b0;
        st = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (!stallreq) break;
            st++;
        end
        stall_i = 1'b1;
        ok = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (stallreq !== 1'b0 || hi_o !== old_hi || lo_o !== old_lo) ok = 1'b0;
        end
        compared++;
        if (!ok || st != DIV_STALLS) begin
            mismatched++;
            $display("FAIL done_hold: got stalls=%0d hold_ok=%b hi=%h lo=%h expected stalls=%0d hold_ok=1 hi=%h lo=%h",
                     st, ok, hi_o, lo_o, DIV_STALLS, old_hi, old_lo);
        end
        #1 stall_i = 1'b0;
        @(posedge clk); #1;
        drive_nop();
        model_hi = 32'd6; model_lo = 32'd142;
        compared++;
        if (hi_o !== model_hi || lo_o !== model_lo) begin
            mismatched++;
            $display("FAIL done_commit: got hi=%h lo=%h expected hi=%h lo=%h", hi_o, lo_o, model_hi, model_lo);
        end
        run_op(OP_MTHI, SEL_NOP, 32'hCAFE_0003, 32'h0, 1'b0, st, wd, wo);
        model_hi = 32'hCAFE_0003;
        run_op(OP_MFHI, SEL_MOVE, 32'h0, 32'h0, 1'b1, st, wd, wo);
        compared++;
        if (wd !== model_hi || lo_o !== model_lo || st != 0) begin
            mismatched++;
            $display("FAIL single_commit: got mfhi=%h lo=%h stalls=%0d expected mfhi=%h lo=%h stalls=0",
                     wd, lo_o, st, model_hi, model_lo);
        end
    endtask

    task automatic test_reset_mid_div();
        int st; logic [31:0] wd; logic wo;
        set_hilo(32'h0BAD_F00D, 32'h0000_BEEF);
        aluop_i = OP_DIV; alusel_i = SEL_NOP; reg1_i = 32'd12345; reg2_i = 32'd11; wreg_i = 1'b0;
        repeat (6) @(posedge clk);
        #2 rst = 1'b0;
        #1;
        model_hi = '0; model_lo = '0;
        compared++;
        if (stallreq !== 1'b0 || hi_o !== 32'h0 || lo_o !== 32'h0 || wreg_o !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_mid_div: got stallreq=%b hi=%h lo=%h wreg=%b expected 0 0 0 0",
                     stallreq, hi_o, lo_o, wreg_o);
        end
        drive_nop();
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_op(OP_OR, SEL_LOGIC, 32'h0F0F_0000, 32'h0000_00FF, 1'b1, st, wd, wo);
        compared++;
        if (wd !== 32'h0F0F_00FF || wo !== 1'b1 || st != 0 || hi_o !== 32'h0 || lo_o !== 32'h0) begin
            mismatched++;
            $display("FAIL or_after_reset: got data=%h wreg=%b stalls=%0d hi=%h lo=%h expected 0f0f00ff 1 0 0 0",
                     wd, wo, st, hi_o, lo_o);
        end
    endtask

    initial begin
        rst = 1'b0; stall_i = 1'b0; flush_i = 1'b0; link_address_i = '0; wd_i = '0;
        drive_nop();
        test_reset();
        test_single_cycle();
        test_mult();
        test_div();
        test_flush();
        test_stall_in_done();
        test_reset_mid_div();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
